// File: rtl/rf_port_seq.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// rf_port_seq
//
// Shares a single register-file port between an operand-fetch requester and a
// writeback source. Writebacks win arbitration in IDLE, but only for
// STARVE_LIMIT consecutive cycles while a request is waiting. An accepted
// request reads rs1 (RD1), optionally rs2 (RD2), then presents the operand
// pair in HOLD until the consumer takes it. Writebacks flow freely in HOLD.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            operand-fetch request handshake
//   req_rs1, req_rs2, req_use2     source ids; use2=0 returns op_b=0
//   op_valid/op_ready, op_a, op_b  operand-pair handshake and data
//   wb_valid/wb_ready              writeback handshake
//   wb_id, wb_value                writeback target and data
//   rf_id, rf_write, rf_value      register-file port id / write strobe / data
//   rf_read                        register-file read strobe
//   rf_out                         asynchronous register-file read data
// -----------------------------------------------------------------------------
module rf_port_seq #(
    parameter int REG_ID_LEN   = 4,
    parameter int REG_SIZE     = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [REG_ID_LEN-1:0] req_rs1,
    input  logic [REG_ID_LEN-1:0] req_rs2,
    input  logic                  req_use2,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [REG_SIZE-1:0]   op_a,
    output logic [REG_SIZE-1:0]   op_b,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [REG_ID_LEN-1:0] wb_id,
    input  logic [REG_SIZE-1:0]   wb_value,
    output logic [REG_ID_LEN-1:0] rf_id,
    output logic                  rf_write,
    output logic [REG_SIZE-1:0]   rf_value,
    output logic                  rf_read,
    input  logic [REG_SIZE-1:0]   rf_out
);

    // Counter wide enough to hold STARVE_LIMIT itself (it saturates there).
    localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        RD1,
        RD2,
        HOLD
    } state_t;

    state_t                state, state_nx;
    logic [REG_ID_LEN-1:0] rs1_q, rs2_q;
    logic                  use2_q;
    logic [CNT_W-1:0]      starve_cnt, starve_nx;
    logic                  req_acc;
    logic                  wb_acc;

    // Next-state, arbitration and register-file port drive.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_nx  = state;
        starve_nx = starve_cnt;
        req_ready = 1'b0;
        wb_ready  = 1'b0;
        rf_read   = 1'b0;
        rf_write  = 1'b0;
        rf_id     = '0;
        rf_value  = '0;

        case (state)
            IDLE: begin
                if (wb_valid && starve_cnt < LIMIT) begin
                    // Writeback wins; count it against a waiting request.
                    // The < LIMIT guard makes the counter saturate.
                    wb_ready = 1'b1;
                    if (req_valid) starve_nx = starve_cnt + CNT_W'(1);
                end else begin
                    req_ready = 1'b1;
                    wb_ready  = !req_valid;
                end
                if (!req_valid) starve_nx = '0;
            end
            RD1: begin
                rf_read  = 1'b1;
                rf_id    = rs1_q;
                state_nx = use2_q ? RD2 : HOLD;
            end
            RD2: begin
                rf_read  = 1'b1;
                rf_id    = rs2_q;
                state_nx = HOLD;
            end
            HOLD: begin
                wb_ready = wb_valid;
                if (op_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // Handshakes are suppressed while reset is held.
        if (rst) begin
            req_ready = 1'b0;
            wb_ready  = 1'b0;
            rf_read   = 1'b0;
        end

        req_acc = req_valid && req_ready;
        wb_acc  = wb_valid && wb_ready;

        if (req_acc) begin
            state_nx  = RD1;
            starve_nx = '0;
        end

        // Writes only happen in IDLE/HOLD, so they never collide with a read.
        if (wb_acc) begin
            rf_write = 1'b1;
            rf_id    = wb_id;
            rf_value = wb_value;
        end
    end

    assign op_valid = (state == HOLD) && !rst;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            // NOTE: only control and operand registers are reset; the register
            // file itself lives outside this block and keeps its contents.
            state      <= IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            use2_q     <= 1'b0;
            starve_cnt <= '0;
            op_a       <= '0;
            op_b       <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            if (req_acc) begin
                rs1_q  <= req_rs1;
                rs2_q  <= req_rs2;
                use2_q <= req_use2;
            end
            // Operands are captured only during the read states, so a HOLD
            // writeback to rs1/rs2 leaves the presented pair untouched.
            if (state == RD1) begin
                op_a <= rf_out;
                if (!use2_q) op_b <= '0;
            end
            if (state == RD2) op_b <= rf_out;
        end
    end

endmodule

// File: tb/tb_rf_port_seq.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_rf_port_seq
//
// Drives rf_port_seq against a small behavioural register file. A shadow copy
// of the register contents is kept from observed writebacks; each accepted
// request pushes its expected operand pair and due cycle into a scoreboard,
// and a negedge monitor pops and compares whenever op_valid rises.
// -----------------------------------------------------------------------------
module tb_rf_port_seq;

  localparam int IDW = 4;
  localparam int DW  = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [IDW-1:0] req_rs1, req_rs2;
  logic           req_use2;
  logic           op_valid;
  logic           op_ready;
  logic [DW-1:0]  op_a, op_b;
  logic           wb_valid;
  logic           wb_ready;
  logic [IDW-1:0] wb_id;
  logic [DW-1:0]  wb_value;
  logic [IDW-1:0] rf_id;
  logic           rf_write;
  logic [DW-1:0]  rf_value;
  logic           rf_read;
  logic [DW-1:0]  rf_out;

  rf_port_seq #(.REG_ID_LEN(IDW), .REG_SIZE(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_use2(req_use2),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_id(wb_id), .wb_value(wb_value),
    .rf_id(rf_id), .rf_write(rf_write), .rf_value(rf_value), .rf_read(rf_read),
    .rf_out(rf_out)
  );

  always #5 clk = ~clk;

  // Behavioural register file attached to the port.
  logic          mem_clr;
  logic [DW-1:0] mem [16];
  assign rf_out = mem[rf_id];
  always @(posedge clk) begin
    if (mem_clr) mem <= '{default: '0};
    else if (rf_write) mem[rf_id] <= rf_value;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Counters and check helper.
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and reference state.
  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            due;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  logic [DW-1:0] shadow [16];
  logic [DW-1:0] hold_a, hold_b, last_a, last_b;
  bit            prev_opv = 0, prev_rst = 0;
  bit            req_acc = 0, wb_acc = 0, mon_rd = 0, mon_wbr = 0, mon_wr = 0, mon_opv = 0;
  logic          wr;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mem_clr) shadow = '{default: '0};
    req_acc = req_valid && req_ready;
    wb_acc  = wb_valid && wb_ready;
    mon_rd  = rf_read;
    mon_wbr = wb_ready;
    mon_wr  = rf_write;
    mon_opv = op_valid;
    if (rst) begin
      check("rst_outputs", {59'd0, req_ready, wb_ready, rf_write, rf_read, op_valid}, '0);
      sb.delete();
      prev_opv = 0;
    end else begin
      if (prev_rst) begin
        check("rst_op_a", op_a, '0);
        check("rst_op_b", op_b, '0);
      end
      wr = wb_valid && wb_ready;
      check("rd_wr_exclusive", {63'd0, rf_read && rf_write}, '0);
      check("rf_write", {63'd0, rf_write}, {63'd0, wr});
      if (wr) begin
        check("rf_id_wr", {60'd0, rf_id}, {60'd0, wb_id});
        check("rf_value_wr", rf_value, wb_value);
      end else begin
        check("rf_value_idle", rf_value, '0);
      end
      if (!rf_read && !rf_write) check("rf_id_idle", {60'd0, rf_id}, '0);
      if (req_valid && req_ready) begin
        check("grant_exclusive", {63'd0, wr}, '0);
        e.a   = shadow[req_rs1];
        e.b   = req_use2 ? shadow[req_rs2] : '0;
        e.due = cyc + (req_use2 ? 3 : 2);
        sb.push_back(e);
      end
      if (op_valid && !prev_opv) begin
        if (sb.size() == 0) begin
          check("op_unexpected", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("op_latency", 64'(cyc), 64'(e.due));
          check("op_a", op_a, e.a);
          check("op_b", op_b, e.b);
          hold_a = e.a;
          hold_b = e.b;
          last_a = op_a;
          last_b = op_b;
        end
      end else if (op_valid) begin
        check("op_a_stable", op_a, hold_a);
        check("op_b_stable", op_b, hold_b);
      end
      prev_opv = op_valid;
      if (wr) shadow[wb_id] = wb_value;
    end
    prev_rst = rst;
  end

  // Driver helpers; flags read after tick() describe the cycle just ended.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [IDW-1:0] id, input logic [DW-1:0] val);
    wb_valid = 1'b1;
    wb_id    = id;
    wb_value = val;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (wb_acc) break;
    end
    check("wb_accept", {63'd0, wb_acc}, 64'd1);
    wb_valid = 1'b0;
  endtask

  task automatic run_req(input logic [IDW-1:0] rs1, input logic [IDW-1:0] rs2,
                         input logic use2, input int exp_reads);
    int reads;
    req_valid = 1'b1;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_use2  = use2;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (req_acc) break;
    end
    check("req_accept", {63'd0, req_acc}, 64'd1);
    req_valid = 1'b0;
    reads = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      reads += int'(mon_rd);
    end
    check("rf_read_cycles", 64'(reads), 64'(exp_reads));
  endtask

  initial begin
    int wins, n;
    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_use2 = 1'b0;
    op_ready = 1'b0; wb_valid = 1'b0; wb_id = '0; wb_value = '0;
    repeat (3) tick();
    rst = 1'b0; mem_clr = 1'b0;
    tick();

    // Preload and two-operand / one-operand fetches.
    do_write(4'd3, 64'h11);
    do_write(4'd5, 64'h22);
    do_write(4'd7, 64'hAB);
    op_ready = 1'b1;
    run_req(4'd3, 4'd5, 1'b1, 2);
    check("dir_use2_a", last_a, 64'h11);
    check("dir_use2_b", last_b, 64'h22);
    run_req(4'd7, 4'd2, 1'b0, 1);
    check("dir_use1_a", last_a, 64'hAB);
    check("dir_use1_b", last_b, 64'h0);

    // Writeback to rs1 while operands are held.
    op_ready = 1'b0;
    run_req(4'd3, 4'd5, 1'b1, 2);
    wb_valid = 1'b1; wb_id = 4'd3; wb_value = 64'h99;
    tick();
    check("hold_wb_commit", {63'd0, wb_acc}, 64'd1);
    wb_valid = 1'b0;
    repeat (2) tick();
    check("hold_op_a", op_a, 64'h11);
    op_ready = 1'b1;
    tick();
    run_req(4'd3, 4'd0, 1'b0, 1);
    check("r3_readback", last_a, 64'h99);

    // Continuous writebacks against a pending request.
    req_valid = 1'b1; req_rs1 = 4'd5; req_rs2 = 4'd7; req_use2 = 1'b1;
    wb_valid = 1'b1; wb_id = 4'd9; wb_value = {$urandom, $urandom};
    wins = 0;
    for (n = 1; n <= 30; n++) begin
      tick();
      if (wb_acc) begin
        wins++;
        wb_id    = 4'(9 + wins);
        wb_value = {$urandom, $urandom};
      end
      if (req_acc) break;
    end
    check("starve_wins", 64'(wins), 64'd4);
    check("starve_grant_cycle", 64'(n), 64'd5);
    check("starve_wb_blocked", {63'd0, mon_wbr}, 64'd0);
    req_valid = 1'b0;
    tick();
    check("rd1_wb_blocked", {63'd0, mon_wbr}, 64'd0);
    tick();
    check("rd2_wb_blocked", {63'd0, mon_wbr}, 64'd0);
    tick();
    check("hold_wb_free", {63'd0, wb_acc}, 64'd1);
    wb_valid = 1'b0;
    repeat (2) tick();

    // Reset while in RD2 abandons the request.
    req_valid = 1'b1; req_rs1 = 4'd5; req_rs2 = 4'd3; req_use2 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (req_acc) break;
    end
    check("rst_req_accept", {63'd0, req_acc}, 64'd1);
    req_valid = 1'b0;
    tick();
    rst = 1'b1; wb_valid = 1'b1; wb_id = 4'd4; wb_value = 64'hDEAD;
    tick();
    check("rst_no_write", {63'd0, mon_wr}, 64'd0);
    rst = 1'b0; wb_valid = 1'b0;
    tick();
    check("post_rst_no_write", {63'd0, mon_wr}, 64'd0);
    check("post_rst_opv", {63'd0, mon_opv}, 64'd0);
    run_req(4'd5, 4'd3, 1'b1, 2);
    check("post_rst_a", last_a, 64'h22);
    check("post_rst_b", last_b, 64'h99);

    // Random traffic; requests and writebacks are held until accepted.
    for (int i = 0; i < 3000; i++) begin
      if (!req_valid || req_acc) begin
        req_valid = ($urandom_range(0, 99) < 40);
        req_rs1   = 4'($urandom);
        req_rs2   = 4'($urandom);
        req_use2  = 1'($urandom);
      end
      if (!wb_valid || wb_acc) begin
        wb_valid = ($urandom_range(0, 99) < 50);
        wb_id    = 4'($urandom);
        wb_value = {$urandom, $urandom};
      end
      op_ready = ($urandom_range(0, 99) < 60);
      tick();
    end

    req_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b1;
    repeat (8) tick();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
